// File: rtl/dsadc_pkg.sv
// Shared state encoding and default sizing for the dual-slope ADC datapath and its control FSM.
// Constants only; no latency or backpressure.
package dsadc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_INTEG = 2'b01,
        S_DEINT = 2'b10,
        S_HOLD  = 2'b11
    } state_t;

    localparam int DSADC_WIDTH = 8;
    localparam int DSADC_N_INT = 200;

endpackage

// File: rtl/dsadc_sat_counter.sv
// Saturating up-counter with sync clear, load-zero and sticky overflow; updates on the edge after inputs.
// No backpressure: increments whenever enabled, overflow records an increment attempted at full scale.
module dsadc_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_enb,
    input  logic             i_ld_zero,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_sat,
    output logic             o_ovf
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic             w_sat;

    assign w_sat = (r_cnt == MAX);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_ld_zero) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (i_enb) begin
            if (w_sat) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = w_sat;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/dual_slope_counter.sv
// Dual-slope ADC timebase: times N_INT integration edges, counts de-integration, latches result on ld.
// Result visible the edge after ld; no backpressure, enb_cnt pauses counting, clr/rst restart.
module dual_slope_counter
    import dsadc_pkg::*;
#(
    parameter int WIDTH = DSADC_WIDTH,
    parameter int N_INT = DSADC_N_INT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             enb_cnt,
    input  logic             ld,
    output logic             enb_machine,
    output logic [WIDTH-1:0] dout,
    output logic             data_valid,
    output logic             res_ovf,
    output logic [1:0]       phase
);

    // N_INT may equal 2**WIDTH, so the terminal value is taken modulo the counter width.
    localparam logic [WIDTH-1:0] TERM = WIDTH'(N_INT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_cnt;
    logic             w_sat;
    logic             w_ovf;
    logic             w_cnt_inc;
    logic             w_cnt_ld0;
    logic             w_load_res;
    logic [WIDTH-1:0] r_dout;
    logic             r_res_ovf;
    logic             r_data_valid;

    dsadc_sat_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (clr),
        .i_enb     (w_cnt_inc),
        .i_ld_zero (w_cnt_ld0),
        .o_cnt     (w_cnt),
        .o_sat     (w_sat),
        .o_ovf     (w_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        w_cnt_ld0   = 1'b0;
        w_load_res  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enb_cnt) begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = S_INTEG;
                end
            end
            S_INTEG: begin
                if (enb_cnt) begin
                    if (w_cnt == TERM) begin
                        w_cnt_ld0   = 1'b1;
                        w_state_nxt = S_DEINT;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_DEINT: begin
                // ld wins over enb_cnt so the latched value is the pre-increment count.
                if (ld) begin
                    w_load_res  = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (enb_cnt) begin
                    w_cnt_inc = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_res_ovf    <= 1'b0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (!clr && w_load_res) begin
                r_dout       <= w_cnt;
                r_res_ovf    <= w_ovf;
                r_data_valid <= 1'b1;
            end
        end
    end

    // Both DEINT and HOLD have the MSB set, so the flag is a plain register bit.
    assign enb_machine = r_state[1];
    assign phase       = r_state;
    assign dout        = r_dout;
    assign res_ovf     = r_res_ovf;
    assign data_valid  = r_data_valid;

endmodule

// File: tb/tb_dual_slope_counter.sv
// Directed bench for dual_slope_counter (WIDTH=8, N_INT=200) with a result scoreboard.
module tb_dual_slope_counter;

    logic       clk = 1'b0;
    logic       rst, clr, enb_cnt, ld;
    logic       enb_machine, data_valid, res_ovf;
    logic [7:0] dout;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    dual_slope_counter #(.WIDTH(8), .N_INT(200)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .enb_cnt     (enb_cnt),
        .ld          (ld),
        .enb_machine (enb_machine),
        .dout        (dout),
        .data_valid  (data_valid),
        .res_ovf     (res_ovf),
        .phase       (phase)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every data_valid cycle must match the oldest expected result.
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_valid: got dout=%0d res_ovf=%0d with nothing expected", dout, res_ovf);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("result_dout", int'(dout), int'(e[7:0]));
                chk("result_ovf", int'(res_ovf), int'(e[8]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic integrate();
        enb_cnt = 1'b1;
        tick(199);
        chk("integ_199_enb_machine", int'(enb_machine), 0);
        tick(1);
        chk("integ_done_enb_machine", int'(enb_machine), 1);
        chk("integ_done_phase", int'(phase), 2);
    endtask

    task automatic load_result(input int exp_dout, input int exp_ovf, input logic enb);
        enb_cnt = enb;
        ld      = 1'b1;
        exp_q.push_back({exp_ovf[0], exp_dout[7:0]});
        tick(1);
        ld      = 1'b0;
        enb_cnt = 1'b0;
        chk("load_phase_hold", int'(phase), 3);
        tick(1);
        chk("dv_one_cycle", int'(data_valid), 0);
    endtask

    task automatic clear_once();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_phase", int'(phase), 0);
        chk("clr_enb_machine", int'(enb_machine), 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; enb_cnt = 1'b0; ld = 1'b0;
        tick(3);
        chk("rst_dout", int'(dout), 0);
        chk("rst_dv", int'(data_valid), 0);
        chk("rst_ovf", int'(res_ovf), 0);
        chk("rst_enb_machine", int'(enb_machine), 0);
        chk("rst_phase", int'(phase), 0);
        rst = 1'b0;
        tick(2);
        chk("idle_phase", int'(phase), 0);
        chk("idle_dout", int'(dout), 0);

        // Nominal conversion
        enb_cnt = 1'b1;
        tick(1);
        chk("first_edge_phase", int'(phase), 1);
        tick(198);
        chk("edge199_enb_machine", int'(enb_machine), 0);
        tick(1);
        chk("edge200_enb_machine", int'(enb_machine), 1);
        chk("edge200_phase", int'(phase), 2);
        tick(37);
        load_result(37, 0, 1'b0);
        chk("hold_enb_machine", int'(enb_machine), 1);
        clear_once();
        chk("clr_keeps_dout", int'(dout), 37);

        // Saturation, then a clean conversion with ld and enb_cnt together
        integrate();
        tick(300);
        load_result(255, 1, 1'b0);
        clear_once();
        chk("clr_keeps_ovf", int'(res_ovf), 1);
        integrate();
        tick(50);
        load_result(50, 0, 1'b1);
        clear_once();

        // Pause during integration
        enb_cnt = 1'b1;
        tick(100);
        enb_cnt = 1'b0;
        tick(10);
        chk("pause_phase", int'(phase), 1);
        chk("pause_enb_machine", int'(enb_machine), 0);
        enb_cnt = 1'b1;
        tick(99);
        chk("pause_199_enb_machine", int'(enb_machine), 0);
        tick(1);
        chk("pause_200_enb_machine", int'(enb_machine), 1);

        // ld together with clr in DEINT is dropped
        tick(5);
        enb_cnt = 1'b0;
        ld = 1'b1; clr = 1'b1;
        tick(1);
        ld = 1'b0; clr = 1'b0;
        chk("ldclr_phase", int'(phase), 0);
        chk("ldclr_dout", int'(dout), 50);
        chk("ldclr_dv", int'(data_valid), 0);

        // ld during INTEG is ignored
        enb_cnt = 1'b1;
        tick(10);
        enb_cnt = 1'b0;
        ld = 1'b1;
        tick(1);
        ld = 1'b0;
        chk("ld_integ_phase", int'(phase), 1);
        chk("ld_integ_dv", int'(data_valid), 0);
        chk("ld_integ_dout", int'(dout), 50);
        enb_cnt = 1'b1;
        tick(189);
        chk("resume_189_phase", int'(phase), 1);
        tick(1);
        chk("resume_190_phase", int'(phase), 2);
        tick(37);
        load_result(37, 0, 1'b0);
        clear_once();

        // rst mid-DEINT
        integrate();
        tick(20);
        enb_cnt = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_cnt", int'(dut.w_cnt), 0);
        chk("midrst_phase", int'(phase), 0);
        chk("midrst_enb_machine", int'(enb_machine), 0);
        chk("midrst_ovf", int'(res_ovf), 0);

        tick(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
